// File: rtl/cp0_excp_if.sv
// Bundles the MEM-stage exception inputs, CP0 read/write ports and the pipeline control outputs.
interface cp0_excp_if;
   logic        inst_valid;
   logic [31:0] inst_pc;
   logic        in_delayslot;
   logic [6:0]  excp_flags;
   logic [31:0] bad_vaddr;
   logic        eret;
   logic        mtc0_we;
   logic [7:0]  mtc0_addr;
   logic [31:0] mtc0_wdata;
   logic        mfc0_re;
   logic [7:0]  mfc0_addr;
   logic [5:0]  hw_int;
   logic [31:0] mfc0_rdata;
   logic [32:0] CP0_to_ctrl_bus;
   logic        stallreq_for_cp0;

   modport master (
      output inst_valid, inst_pc, in_delayslot, excp_flags, bad_vaddr, eret,
             mtc0_we, mtc0_addr, mtc0_wdata, mfc0_re, mfc0_addr, hw_int,
      input  mfc0_rdata, CP0_to_ctrl_bus, stallreq_for_cp0
   );

   modport slave (
      input  inst_valid, inst_pc, in_delayslot, excp_flags, bad_vaddr, eret,
             mtc0_we, mtc0_addr, mtc0_wdata, mfc0_re, mfc0_addr, hw_int,
      output mfc0_rdata, CP0_to_ctrl_bus, stallreq_for_cp0
   );
endinterface

// File: rtl/cp0_excp.sv
// CP0 exception/interrupt unit: prioritises MEM-stage exceptions, handles ERET and CP0 register access.
// Define CP0_TIMER_EN to build the Count/Compare timer; otherwise those registers read as zero.
module cp0_excp (
   input  logic       clk,
   input  logic       resetn,
   cp0_excp_if.slave  cp0
);
   localparam logic [7:0]  A_BADV    = 8'h40;
   localparam logic [7:0]  A_COUNT   = 8'h48;
   localparam logic [7:0]  A_COMPARE = 8'h58;
   localparam logic [7:0]  A_STATUS  = 8'h60;
   localparam logic [7:0]  A_CAUSE   = 8'h68;
   localparam logic [7:0]  A_EPC     = 8'h70;
   localparam logic [31:0] EXC_VEC   = 32'hBFC0_0380;

   logic [31:0] badv_q, epc_q;
   logic [7:0]  im_q, ip_q;
   logic        exl_q, ie_q, bd_q, ti_q;
   logic [4:0]  exc_q;
   logic [31:0] count_rd, compare_rd;

   logic        int_pend, excp_take, eret_take, mtc0_en;
   logic        badv_from_pc, badv_from_addr;
   logic [4:0]  code;

   always_comb begin
      code           = 5'd0;
      badv_from_pc   = 1'b0;
      badv_from_addr = 1'b0;
      int_pend       = cp0.inst_valid & ie_q & ~exl_q & (|(ip_q & im_q));
      if (int_pend)                 code = 5'd0;
      else if (cp0.excp_flags[6]) begin code = 5'd4;  badv_from_pc = 1'b1; end
      else if (cp0.excp_flags[5])   code = 5'd10;
      else if (cp0.excp_flags[4])   code = 5'd12;
      else if (cp0.excp_flags[3])   code = 5'd8;
      else if (cp0.excp_flags[2])   code = 5'd9;
      else if (cp0.excp_flags[1]) begin code = 5'd4;  badv_from_addr = 1'b1; end
      else if (cp0.excp_flags[0]) begin code = 5'd5;  badv_from_addr = 1'b1; end
      excp_take = int_pend | (cp0.inst_valid & (|cp0.excp_flags));
      eret_take = cp0.inst_valid & cp0.eret & ~excp_take;
      mtc0_en   = cp0.mtc0_we & ~excp_take;
   end

`ifdef CP0_TIMER_EN
   logic [31:0] count_q, compare_q;
   logic        tick_q;

   // Count advances on every other clock; an explicit mtc0 to Count overrides the increment.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tick_q    <= 1'b0;
         count_q   <= 32'd0;
         compare_q <= 32'd0;
         ti_q      <= 1'b0;
      end else begin
         tick_q <= ~tick_q;
         if (mtc0_en && cp0.mtc0_addr == A_COUNT) count_q <= cp0.mtc0_wdata;
         else if (tick_q)                         count_q <= count_q + 32'd1;
         if (mtc0_en && cp0.mtc0_addr == A_COMPARE) begin
            compare_q <= cp0.mtc0_wdata;
            ti_q      <= 1'b0;
         end else if (count_q == compare_q && compare_q != 32'd0) begin
            ti_q <= 1'b1;
         end
      end
   end
   assign count_rd   = count_q;
   assign compare_rd = compare_q;
`else
   assign ti_q       = 1'b0;
   assign count_rd   = 32'd0;
   assign compare_rd = 32'd0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         badv_q <= 32'd0;
         epc_q  <= 32'd0;
         im_q   <= 8'd0;
         ip_q   <= 8'd0;
         exl_q  <= 1'b0;
         ie_q   <= 1'b0;
         bd_q   <= 1'b0;
         exc_q  <= 5'd0;
      end else begin
         ip_q[7:2] <= {cp0.hw_int[5] | ti_q, cp0.hw_int[4:0]};
         if (excp_take) begin
            exl_q <= 1'b1;
            exc_q <= code;
            // A nested exception keeps the original return address and BD flag.
            if (!exl_q) begin
               epc_q <= cp0.in_delayslot ? cp0.inst_pc - 32'd4 : cp0.inst_pc;
               bd_q  <= cp0.in_delayslot;
            end
            if (badv_from_pc)   badv_q <= cp0.inst_pc;
            if (badv_from_addr) badv_q <= cp0.bad_vaddr;
         end else begin
            if (mtc0_en) begin
               case (cp0.mtc0_addr)
                  A_STATUS: begin
                     im_q  <= cp0.mtc0_wdata[15:8];
                     exl_q <= cp0.mtc0_wdata[1];
                     ie_q  <= cp0.mtc0_wdata[0];
                  end
                  A_CAUSE:  ip_q[1:0] <= cp0.mtc0_wdata[9:8];
                  A_EPC:    epc_q     <= cp0.mtc0_wdata;
                  default:  ;
               endcase
            end
            if (eret_take) exl_q <= 1'b0;
         end
      end
   end

   always_comb begin
      cp0.mfc0_rdata = 32'd0;
      if (resetn && cp0.mfc0_re) begin
         case (cp0.mfc0_addr)
            A_BADV:    cp0.mfc0_rdata = badv_q;
            A_COUNT:   cp0.mfc0_rdata = count_rd;
            A_COMPARE: cp0.mfc0_rdata = compare_rd;
            A_STATUS:  cp0.mfc0_rdata = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
            A_CAUSE:   cp0.mfc0_rdata = {bd_q, ti_q, 14'd0, ip_q, 1'b0, exc_q, 2'b00};
            A_EPC:     cp0.mfc0_rdata = epc_q;
            default:   cp0.mfc0_rdata = 32'd0;
         endcase
      end
   end

   always_comb begin
      cp0.CP0_to_ctrl_bus = 33'd0;
      if (resetn) begin
         if (excp_take)      cp0.CP0_to_ctrl_bus = {1'b1, EXC_VEC};
         else if (eret_take) cp0.CP0_to_ctrl_bus = {1'b1, epc_q};
      end
   end

   assign cp0.stallreq_for_cp0 = resetn & cp0.mfc0_re & cp0.mtc0_we &
                                 (cp0.mfc0_addr == cp0.mtc0_addr) & ~excp_take;
endmodule
